// File: rtl/branch_resolver.sv
// Carries fetch-stage direction predictions to M, resolves them and
// drives the misprediction redirect plus saturating perf counters.
module branch_resolver #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pcsrcPF,
  input  logic                 stallD,
  input  logic                 stallE,
  input  logic                 stallM,
  input  logic                 flushD,
  input  logic                 flushE,
  input  logic                 flushM,
  input  logic                 stallF,
  input  logic                 branchM,
  input  logic                 pcsrcM,
  input  logic [PC_WIDTH-1:0]  targetM,
  input  logic [PC_WIDTH-1:0]  pc_plus8M,
  output logic                 pcsrcPM,
  output logic                 mispredictM,
  output logic                 redirect_valid,
  output logic [PC_WIDTH-1:0]  redirect_pc,
  output logic                 flush_fde,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispred_cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic                predD;
  logic                predE;
  logic                predM;
  logic [0:0]          state;
  logic [PC_WIDTH-1:0] holdPc;
  logic [PC_WIDTH-1:0] fixPc;
  logic                resolve;
  logic                inHold;

  assign resolve = branchM & ~stallM;
  assign inHold  = (state == HOLD);
  assign fixPc   = pcsrcM ? targetM : pc_plus8M;
  assign pcsrcPM = predM;

  assign mispredictM    = resolve & (predM ^ pcsrcM) & ~inHold;
  assign redirect_valid = inHold | mispredictM;
  assign flush_fde      = redirect_valid;
  assign redirect_pc    = inHold ? holdPc : fixPc;

  // Flush beats stall beats load on every stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      predD <= 1'b0;
      predE <= 1'b0;
      predM <= 1'b0;
    end else begin
      if (flushD)       predD <= 1'b0;
      else if (!stallD) predD <= pcsrcPF;
      if (flushE)       predE <= 1'b0;
      else if (!stallE) predE <= predD;
      if (flushM)       predM <= 1'b0;
      else if (!stallM) predM <= predE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      holdPc <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mispredictM && stallF) begin
            holdPc <= fixPc;
            state  <= HOLD;
          end
        end
        HOLD: begin
          if (!stallF) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (resolve && (branch_cnt != '1))
        branch_cnt <= branch_cnt + 1'b1;
      if (mispredictM && (mispred_cnt != '1))
        mispred_cnt <= mispred_cnt + 1'b1;
    end
  end

endmodule
